// File: rtl/sccb_init_seq.sv
// Camera bring-up sequencer: walks a {reg,val} table, issues SCCB writes,
// honours delay entries and the end marker, and retries NACKed writes a bounded number of times.
module sccb_init_seq #(
  parameter int ADDR_W        = 8,
  parameter int CYCLES_PER_MS = 12000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              sccb_req,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_wdata,
  input  logic              sccb_ack,
  input  logic              sccb_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] fail_index
);

  localparam int DLY_W = $clog2(255 * CYCLES_PER_MS + 1);
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [DLY_W-1:0] CPM     = DLY_W'(CYCLES_PER_MS);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);
  localparam logic [7:0]       MARK    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    WRITE  = 3'd3,
    DELAY  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t           state_r;
  logic [DLY_W-1:0] dly_cnt_r;
  logic [RTY_W-1:0] retry_r;
  logic             last_entry_s;
  logic [DLY_W-1:0] dly_load_s;

  // The table never wraps: the last address finishes the sequence.
  assign last_entry_s = (tbl_addr == {ADDR_W{1'b1}});
  // Loaded as count-1 so DELAY lasts exactly N*CYCLES_PER_MS cycles.
  assign dly_load_s   = DLY_W'(tbl_data[7:0]) * CPM - DLY_W'(1'b1);

  // Sequencer state, table pointer, SCCB request and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      tbl_addr   <= {ADDR_W{1'b0}};
      fail_index <= {ADDR_W{1'b0}};
      sccb_req   <= 1'b0;
      sccb_reg   <= 8'h00;
      sccb_wdata <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      dly_cnt_r  <= {DLY_W{1'b0}};
      retry_r    <= {RTY_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_r  <= FETCH;
            tbl_addr <= {ADDR_W{1'b0}};
            retry_r  <= {RTY_W{1'b0}};
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        FETCH: state_r <= DECODE;
        DECODE: begin
          if (tbl_data[15:8] != MARK) begin
            sccb_reg   <= tbl_data[15:8];
            sccb_wdata <= tbl_data[7:0];
            sccb_req   <= 1'b1;
            state_r    <= WRITE;
          end else if (tbl_data[7:0] == MARK) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (tbl_data[7:0] != 8'h00) begin
            dly_cnt_r <= dly_load_s;
            state_r   <= DELAY;
          end else if (last_entry_s) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            tbl_addr <= tbl_addr + ADDR_W'(1'b1);
            state_r  <= FETCH;
          end
        end
        WRITE: begin
          if (sccb_ack) begin
            sccb_req <= 1'b0;
            if (!sccb_nack) begin
              retry_r <= {RTY_W{1'b0}};
              if (last_entry_s) begin
                state_r <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                tbl_addr <= tbl_addr + ADDR_W'(1'b1);
                state_r  <= FETCH;
              end
            end else if (retry_r < RTY_MAX) begin
              // Re-fetching the same address keeps req low for the re-issue gap.
              retry_r <= retry_r + RTY_W'(1'b1);
              state_r <= FETCH;
            end else begin
              state_r    <= ERROR;
              busy       <= 1'b0;
              error      <= 1'b1;
              fail_index <= tbl_addr;
            end
          end
        end
        DELAY: begin
          if (dly_cnt_r != {DLY_W{1'b0}}) begin
            dly_cnt_r <= dly_cnt_r - DLY_W'(1'b1);
          end else if (last_entry_s) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            tbl_addr <= tbl_addr + ADDR_W'(1'b1);
            state_r  <= FETCH;
          end
        end
        default: begin
          state_r  <= IDLE;
          sccb_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: a transaction-level model predicts the write stream, final status
// and busy length from the table and NACK plan; a per-cycle check compares the DUT against it.
module tb_sccb_init_seq;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int CPM   = 10;
  localparam int MAXR  = 3;
  localparam int LIMIT = 3000;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic          sccb_req;
  logic [7:0]    sccb_reg;
  logic [7:0]    sccb_wdata;
  logic          sccb_ack;
  logic          sccb_nack;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] fail_index;

  sccb_init_seq #(.ADDR_W(AW), .CYCLES_PER_MS(CPM), .MAX_RETRIES(MAXR)) dut (
    .clk(clk), .reset(reset), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .sccb_req(sccb_req), .sccb_reg(sccb_reg), .sccb_wdata(sccb_wdata),
    .sccb_ack(sccb_ack), .sccb_nack(sccb_nack), .busy(busy), .done(done),
    .error(error), .fail_index(fail_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] tbl [DEPTH];
  bit          nack_plan [512];
  int          ack_lat;
  bit          stray_en;
  int          rsp_cnt;

  // Table memory: data valid one cycle after the address
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  // SCCB slave: acks after ack_lat cycles of req, NACKs according to the plan
  initial begin
    int wait_cnt;
    int scnt;
    sccb_ack = 1'b0; sccb_nack = 1'b0; rsp_cnt = 0; wait_cnt = 0; scnt = 0;
    forever begin
      @(posedge clk); #1;
      sccb_ack = 1'b0; sccb_nack = 1'b0;
      if (sccb_req) begin
        if (wait_cnt >= ack_lat) begin
          sccb_ack = 1'b1; sccb_nack = nack_plan[rsp_cnt]; rsp_cnt++; wait_cnt = 0;
        end else wait_cnt++;
      end else begin
        wait_cnt = 0;
        if (stray_en) begin
          scnt++;
          if (scnt % 3 == 0) begin sccb_ack = 1'b1; sccb_nack = scnt[0]; end
        end
      end
    end
  end

  int          checks, errors;
  logic [15:0] exp_wr_q [$];
  bit          exp_done, exp_err, exp_busy_ok;
  int          exp_fail, exp_addr, exp_busy, busy_cyc;
  bit          chk_en, req_prev, ack_prev;
  logic [15:0] held;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sequence model: walks the table by its rules, consuming one plan bit per request.
  task automatic model_run(input int base, input int lat);
    int idx, k, att;
    bit fin, nk;
    logic [7:0] r, v;
    exp_wr_q.delete();
    exp_done = 0; exp_err = 0; exp_fail = 0; exp_busy = 0; exp_busy_ok = 1;
    idx = 0; k = base; fin = 0;
    while (!fin) begin
      r = tbl[idx][15:8]; v = tbl[idx][7:0];
      exp_busy += 2;
      if (r == 8'hFF && v == 8'hFF) begin
        exp_done = 1; fin = 1;
      end else begin
        if (r == 8'hFF) exp_busy += int'(v) * CPM;
        else begin
          att = 0;
          forever begin
            exp_wr_q.push_back(tbl[idx]);
            exp_busy += lat + 1;
            nk = nack_plan[k]; k++;
            if (!nk) break;
            exp_busy_ok = 0;
            if (att == MAXR) begin exp_err = 1; exp_fail = idx; fin = 1; break; end
            att++;
          end
        end
        if (!fin) begin
          if (idx == DEPTH - 1) begin exp_done = 1; fin = 1; end
          else idx++;
        end
      end
    end
    exp_addr = idx;
  endtask

  // One clock step plus the per-cycle output checks
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      if (busy) busy_cyc++;
      check("status_onehot", 32'($countones({busy, done, error}) <= 1), 32'd1);
      if (sccb_req) check("req_only_busy", 32'(busy), 32'd1);
      if (ack_prev) check("req_low_after_ack", 32'(sccb_req), 32'd0);
      if (sccb_req && !req_prev) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_write: got %0h expected none", {sccb_reg, sccb_wdata});
        end else check("write_data", 32'({sccb_reg, sccb_wdata}), 32'(exp_wr_q.pop_front()));
        held = {sccb_reg, sccb_wdata};
      end else if (sccb_req) check("write_hold", 32'({sccb_reg, sccb_wdata}), 32'(held));
      ack_prev = sccb_req && sccb_ack;
      req_prev = sccb_req;
    end
  endtask

  task automatic set_plan(input logic [7:0] p);
    for (int j = 0; j < 8; j++) nack_plan[rsp_cnt + j] = p[j];
  endtask

  task automatic run_dut(input string nm, input int poke);
    int n;
    busy_cyc = 0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (busy && n < LIMIT) begin
      start = (n == poke);
      tick();
      n++;
    end
    start = 1'b0;
    if (n >= LIMIT) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, n);
    end
    check({nm, "_done"}, 32'(done), 32'(exp_done));
    check({nm, "_error"}, 32'(error), 32'(exp_err));
    check({nm, "_addr"}, 32'(tbl_addr), 32'(exp_addr));
    check({nm, "_writes_left"}, 32'(exp_wr_q.size()), 32'd0);
    if (exp_err) check({nm, "_fail_index"}, 32'(fail_index), 32'(exp_fail));
    if (exp_busy_ok) check({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    exp_wr_q.delete();
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; chk_en = 0; req_prev = 0; ack_prev = 0; held = 16'h0;
    reset = 1'b1; start = 1'b0; ack_lat = 0; stray_en = 0;
    tbl = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    repeat (3) tick();
    check("reset_state", 32'({sccb_req, busy, done, error, sccb_reg, sccb_wdata, tbl_addr, fail_index}), 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    check("idle_after_reset", 32'({sccb_req, busy, done, error}), 32'd0);
    chk_en = 1;

    // Two writes then end marker
    tbl = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
    set_plan(8'h00); model_run(rsp_cnt, 0);
    check("model_t1_count", 32'(exp_wr_q.size()), 32'd2);
    check("model_t1_first", 32'(exp_wr_q[0]), 32'h1280);
    check("model_t1_busy", 32'(exp_busy), 32'd8);
    ack_lat = 0; run_dut("t1", -1);
    check("t1_done_lit", 32'({done, busy}), 32'b10);

    // 2 ms delay, stray acks and a start pulse while busy
    tbl = '{16'hFF02, 16'hFFFF, 16'h0000, 16'h0000};
    set_plan(8'h00); model_run(rsp_cnt, 0);
    check("model_t2_busy", 32'(exp_busy), 32'd24);
    stray_en = 1; run_dut("t2", 10); stray_en = 0;

    // Zero delay, slow ack, 1 ms delay
    tbl = '{16'hFF00, 16'h2155, 16'hFF01, 16'hFFFF};
    set_plan(8'h00); model_run(rsp_cnt, 2);
    check("model_t3_busy", 32'(exp_busy), 32'd21);
    ack_lat = 2; run_dut("t3", -1);

    // One NACK then ACK
    tbl = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
    set_plan(8'h01); model_run(rsp_cnt, 1);
    check("model_t4_count", 32'(exp_wr_q.size()), 32'd3);
    check("model_t4_retry", 32'(exp_wr_q[1]), 32'h1280);
    ack_lat = 1; run_dut("t4", -1);

    // Entry 1 NACKed four times
    tbl = '{16'h1280, 16'h1101, 16'h1322, 16'hFFFF};
    set_plan(8'h1E); model_run(rsp_cnt, 0);
    check("model_t5_count", 32'(exp_wr_q.size()), 32'd5);
    check("model_t5_fail", 32'(exp_fail), 32'd1);
    ack_lat = 0; run_dut("t5", -1);
    check("t5_status_lit", 32'({error, done, fail_index}), 32'b1001);

    // Reset during an outstanding request
    tbl = '{16'h1280, 16'hFFFF, 16'h0000, 16'h0000};
    set_plan(8'h00); model_run(rsp_cnt, 0);
    ack_lat = 1000;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!sccb_req && n < 20) begin tick(); n++; end
    check("req_before_reset", 32'(sccb_req), 32'd1);
    #2 reset = 1'b1; #1;
    check("reset_mid_txn", 32'({sccb_req, busy, done, error, sccb_reg, sccb_wdata, tbl_addr, fail_index}), 32'd0);
    tick(); reset = 1'b0;
    repeat (5) tick();
    check("idle_after_mid_reset", 32'({sccb_req, busy, done, error}), 32'd0);
    exp_wr_q.delete(); ack_lat = 0;

    // No end marker: four writes then stop at the last address
    tbl = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    set_plan(8'h00); model_run(rsp_cnt, 0);
    check("model_t6_addr", 32'(exp_addr), 32'd3);
    check("model_t6_count", 32'(exp_wr_q.size()), 32'd4);
    run_dut("t6", -1);
    repeat (3) tick();
    check("t6_addr_hold", 32'({tbl_addr, done}), 32'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_init_seq.md
SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning table address width (table depth 2^ADDR_W entries).
REQ-002 The block SHALL have parameter CYCLES_PER_MS, default 12000, meaning clk cycles per delay millisecond.
REQ-003 The block SHALL have parameter MAX_RETRIES, default 3, meaning extra attempts after a NACKed write.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins the sequence.
REQ-007 The block SHALL have port tbl_addr, output, ADDR_W bits: table read address.
REQ-008 The block SHALL have port tbl_data, input, 16 bits: {reg[15:8], val[7:0]}, valid exactly 1 cycle after tbl_addr changes.
REQ-009 The block SHALL have port sccb_req, output, 1 bit: write request to the SCCB master.
REQ-010 The block SHALL have port sccb_reg, output, 8 bits: camera register address.
REQ-011 The block SHALL have port sccb_wdata, output, 8 bits: write value.
REQ-012 The block SHALL have port sccb_ack, input, 1 bit: one-cycle pulse, transaction finished.
REQ-013 The block SHALL have port sccb_nack, input, 1 bit: qualified by sccb_ack; high = slave did not acknowledge.
REQ-014 The block SHALL have ports busy, done and error, outputs, 1 bit each: status.
REQ-015 The block SHALL have port fail_index, output, ADDR_W bits: table index of the failing entry.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DECODE, WRITE, DELAY, DONE and ERROR.
REQ-017 IDLE/DONE/ERROR + start SHALL go to FETCH, set tbl_addr=0, clear done, error, retry count; start SHALL be ignored in all other states.
REQ-018 FETCH SHALL last exactly 1 cycle; DECODE SHALL sample tbl_data.
REQ-019 DECODE reg==0xFF, val==0xFF (end marker) SHALL go to DONE.
REQ-020 DECODE reg==0xFF, val==N (N≠0xFF) SHALL go to DELAY for N*CYCLES_PER_MS cycles; N==0 SHALL advance directly to next entry.
REQ-021 DECODE with any other reg SHALL go to WRITE with sccb_reg=reg, sccb_wdata=val, sccb_req=1 from the next cycle.
REQ-022 sccb_req, sccb_reg and sccb_wdata SHALL be held stable until sccb_ack is sampled; sccb_req SHALL be 0 the cycle after ack.
REQ-023 ack with nack=0 SHALL clear retry count and advance; ack with nack=1 SHALL re-issue the same entry (req low ≥1 cycle) if retries < MAX_RETRIES, else go to ERROR with fail_index=tbl_addr.
REQ-024 Advance SHALL mean tbl_addr+1 then FETCH; if tbl_addr==2^ADDR_W-1 the FSM SHALL go to DONE instead (no wrap).
REQ-025 sccb_ack outside WRITE SHALL be ignored.
REQ-026 busy SHALL be 1 in FETCH, DECODE, WRITE and DELAY; done SHALL be 1 in DONE; error SHALL be 1 in ERROR; done/error SHALL hold until next start.
REQ-027 The delay counter SHALL be wide enough for 255*CYCLES_PER_MS without overflow.

Reset
REQ-028 reset SHALL immediately force IDLE, sccb_req=0, tbl_addr=0, sccb_reg=0, sccb_wdata=0, fail_index=0, busy=done=error=0, counters=0, including mid-transaction.
REQ-029 After reset release, the block SHALL stay in IDLE until start.

Verification
REQ-030 Table {0x12,0x80},{0x11,0x01},{0xFF,0xFF}, immediate acks -> two writes 0x12/0x80 then 0x11/0x01, done=1, busy=0.
REQ-031 Table {0xFF,0x02},{0xFF,0xFF}, CYCLES_PER_MS=10 -> busy held ≥20 cycles in DELAY, no sccb_req, then done=1.
REQ-032 Entry 1 NACKed 4 times, MAX_RETRIES=3 -> 4 requests for that entry, error=1, fail_index=1, done=0.
REQ-033 Entry NACKed once then ACKed -> 2 requests, sequence continues, done=1.
REQ-034 reset asserted while sccb_req=1 -> sccb_req=0 same cycle, all outputs 0; start pulsed during busy -> no restart.
REQ-035 ADDR_W=2, table without end marker -> 4 writes (index 0..3), then done=1, tbl_addr stays 3.
